// File: rtl/corr_frame_sequencer.sv
// Frame sequencer: raster-order pixel fetch, pose latch, return-path alignment and drain/done.
// Optional CORR_CNT_EN adds o_corr_cnt, a count of i_corr_valid pulses seen while busy.
module corr_frame_sequencer #(
    parameter int RD_LAT        = 2,
    parameter int ADDR_BW       = 19,
    parameter int DRAIN_MAX     = 64,
    parameter int POSE_BW       = 16,
    parameter int H_SIZE_BW     = 10,
    parameter int V_SIZE_BW     = 10,
    parameter int DATA_RGB_BW   = 24,
    parameter int DATA_DEPTH_BW = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_pose_valid,
    input  logic [11:0][POSE_BW-1:0]      i_pose,
    input  logic [H_SIZE_BW-1:0]          r_hsize,
    input  logic [V_SIZE_BW-1:0]          r_vsize,
    input  logic                          i_rd_ready,
    output logic                          o_rd_en,
    output logic [ADDR_BW-1:0]            o_rd_addr,
    input  logic [DATA_RGB_BW-1:0]        i_rd_data0,
    input  logic [DATA_DEPTH_BW-1:0]      i_rd_depth0,
    output logic                          o_valid,
    output logic                          o_frame_start,
    output logic                          o_frame_end,
    output logic [DATA_RGB_BW-1:0]        o_data0,
    output logic [DATA_DEPTH_BW-1:0]      o_depth0,
    output logic [11:0][POSE_BW-1:0]      o_pose,
    input  logic                          i_corr_valid,
    input  logic                          i_corr_frame_end,
    output logic                          o_busy,
    output logic                          o_done
`ifdef CORR_CNT_EN
    ,
    output logic [ADDR_BW-1:0]            o_corr_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for i_start
    // STREAM | issuing reads in raster order
    // DRAIN  | waiting for the calculator's delayed frame_end (or timeout)
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam int DC_BW = $clog2(DRAIN_MAX + 1);
    localparam logic [DC_BW-1:0]     DC_LAST = DC_BW'(DRAIN_MAX - 1);
    localparam logic [DC_BW-1:0]     DC_ONE  = DC_BW'(1);
    localparam logic [H_SIZE_BW-1:0] H_ONE   = H_SIZE_BW'(1);
    localparam logic [V_SIZE_BW-1:0] V_ONE   = V_SIZE_BW'(1);
    localparam logic [ADDR_BW-1:0]   A_ONE   = ADDR_BW'(1);

    state_t                     state_q;
    logic                       rd_en_q;
    logic                       busy_q;
    logic                       done_q;
    logic [H_SIZE_BW-1:0]       x_q, x_d;
    logic [V_SIZE_BW-1:0]       y_q, y_d;
    logic [ADDR_BW-1:0]         addr_q, addr_d;
    logic [DC_BW-1:0]           drain_cnt_q;
    logic [11:0][POSE_BW-1:0]   pose_q;
    logic [11:0][POSE_BW-1:0]   pend_q;
    logic                       pend_vld_q;

    logic                       rd_acc;
    logic                       x_last, y_last;
    logic                       px_first, px_last;

    logic [RD_LAT-1:0]          sr_vld_q, sr_first_q, sr_last_q;
    logic                       valid_q, fs_q, fe_q;
    logic [DATA_RGB_BW-1:0]     data_q;
    logic [DATA_DEPTH_BW-1:0]   depth_q;

`ifdef CORR_CNT_EN
    logic [ADDR_BW-1:0]         corr_cnt_q;
`else
    logic                       corr_valid_unused;
    assign corr_valid_unused = i_corr_valid;
`endif

    always_comb begin
        rd_acc   = rd_en_q & i_rd_ready;
        x_last   = (x_q == r_hsize - H_ONE);
        y_last   = (y_q == r_vsize - V_ONE);
        px_first = rd_acc & (x_q == '0) & (y_q == '0);
        px_last  = rd_acc & x_last & y_last;
        x_d      = x_last ? '0 : x_q + H_ONE;
        y_d      = x_last ? y_q + V_ONE : y_q;
        addr_d   = addr_q + A_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            drain_cnt_q <= '0;
            pose_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
`ifdef CORR_CNT_EN
            corr_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (i_pose_valid) begin
                pend_q     <= i_pose;
                pend_vld_q <= 1'b1;
            end
`ifdef CORR_CNT_EN
            if (busy_q && i_corr_valid) begin
                corr_cnt_q <= corr_cnt_q + A_ONE;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q    <= S_STREAM;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        x_q        <= '0;
                        y_q        <= '0;
                        addr_q     <= '0;
                        pend_vld_q <= 1'b0;
                        // a same-cycle pose strobe wins over the stored pending pose
                        if (i_pose_valid) begin
                            pose_q <= i_pose;
                        end else if (pend_vld_q) begin
                            pose_q <= pend_q;
                        end
`ifdef CORR_CNT_EN
                        corr_cnt_q <= '0;
`endif
                    end
                end
                S_STREAM: begin
                    if (px_last) begin
                        rd_en_q     <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= S_DRAIN;
                    end else if (rd_acc) begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        addr_q <= addr_d;
                    end
                end
                S_DRAIN: begin
                    if (i_corr_frame_end || drain_cnt_q == DC_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DC_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Flags travel RD_LAT deep so they meet their data; one more stage registers both together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_vld_q   <= '0;
            sr_first_q <= '0;
            sr_last_q  <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
            data_q     <= '0;
            depth_q    <= '0;
        end else begin
            sr_vld_q[0]   <= rd_acc;
            sr_first_q[0] <= px_first;
            sr_last_q[0]  <= px_last;
            for (int i = 1; i < RD_LAT; i++) begin
                sr_vld_q[i]   <= sr_vld_q[i-1];
                sr_first_q[i] <= sr_first_q[i-1];
                sr_last_q[i]  <= sr_last_q[i-1];
            end
            valid_q <= sr_vld_q[RD_LAT-1];
            fs_q    <= sr_first_q[RD_LAT-1];
            fe_q    <= sr_last_q[RD_LAT-1];
            data_q  <= sr_vld_q[RD_LAT-1] ? i_rd_data0  : '0;
            depth_q <= sr_vld_q[RD_LAT-1] ? i_rd_depth0 : '0;
        end
    end

    assign o_rd_en       = rd_en_q;
    assign o_rd_addr     = addr_q;
    assign o_valid       = valid_q;
    assign o_frame_start = fs_q;
    assign o_frame_end   = fe_q;
    assign o_data0       = data_q;
    assign o_depth0      = depth_q;
    assign o_pose        = pose_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
`ifdef CORR_CNT_EN
    assign o_corr_cnt    = corr_cnt_q;
`endif

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// Bench for corr_frame_sequencer: memory responder plus frame-level reference model.
// Build with CORR_CNT_EN defined to also check o_corr_cnt.
module tb_corr_frame_sequencer;

    localparam int RD_LAT    = 2;
    localparam int ADDR_BW   = 19;
    localparam int DRAIN_MAX = 64;
    localparam int POSE_BW   = 16;
    localparam int HB        = 10;
    localparam int VB        = 10;
    localparam int RGB_BW    = 24;
    localparam int DEP_BW    = 16;

    typedef logic [11:0][POSE_BW-1:0] pose_t;

    logic                 i_clk, i_rst_n, i_start, i_pose_valid;
    pose_t                i_pose, o_pose;
    logic [HB-1:0]        r_hsize;
    logic [VB-1:0]        r_vsize;
    logic                 i_rd_ready, o_rd_en;
    logic [ADDR_BW-1:0]   o_rd_addr;
    logic [RGB_BW-1:0]    i_rd_data0, o_data0;
    logic [DEP_BW-1:0]    i_rd_depth0, o_depth0;
    logic                 o_valid, o_frame_start, o_frame_end;
    logic                 i_corr_valid, i_corr_frame_end, o_busy, o_done;
`ifdef CORR_CNT_EN
    logic [ADDR_BW-1:0]   o_corr_cnt;
`endif

    corr_frame_sequencer #(
        .RD_LAT(RD_LAT), .ADDR_BW(ADDR_BW), .DRAIN_MAX(DRAIN_MAX), .POSE_BW(POSE_BW),
        .H_SIZE_BW(HB), .V_SIZE_BW(VB), .DATA_RGB_BW(RGB_BW), .DATA_DEPTH_BW(DEP_BW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pose_valid(i_pose_valid),
        .i_pose(i_pose), .r_hsize(r_hsize), .r_vsize(r_vsize), .i_rd_ready(i_rd_ready),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data0(i_rd_data0),
        .i_rd_depth0(i_rd_depth0), .o_valid(o_valid), .o_frame_start(o_frame_start),
        .o_frame_end(o_frame_end), .o_data0(o_data0), .o_depth0(o_depth0), .o_pose(o_pose),
        .i_corr_valid(i_corr_valid), .i_corr_frame_end(i_corr_frame_end),
        .o_busy(o_busy), .o_done(o_done)
`ifdef CORR_CNT_EN
        , .o_corr_cnt(o_corr_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    int    cyc, n_pix, ready_mode;
    int    exp_addr, out_idx, acc_cnt;
    int    first_acc, last_acc, first_val, last_val, drain_start;
    bit    model_busy, done_flag, prev_rd_en;
    pose_t latest_pose, exp_pose;
    logic [ADDR_BW-1:0] dl_addr [0:RD_LAT];
    logic               dl_vld  [0:RD_LAT];

    function automatic logic [RGB_BW-1:0] rgb_of(input int a);
        logic [31:0] t;
        t = a * 32'h0001_9E37 + 32'h00A5_5A5A;
        return t[RGB_BW-1:0];
    endfunction

    function automatic logic [DEP_BW-1:0] depth_of(input int a);
        logic [31:0] t;
        t = a * 32'h0000_0BD7 + 32'h0000_1234;
        return t[DEP_BW-1:0];
    endfunction

    function automatic pose_t rand_pose();
        pose_t p;
        for (int i = 0; i < 12; i++) p[i] = POSE_BW'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        model_busy = 0; done_flag = 0; prev_rd_en = 0;
        exp_addr = 0; out_idx = 0; acc_cnt = 0;
        first_acc = -1; last_acc = -1; first_val = -1; last_val = -1; drain_start = -1;
        latest_pose = '0; exp_pose = '0;
        for (int i = 0; i <= RD_LAT; i++) begin dl_vld[i] = 0; dl_addr[i] = '0; end
    endtask

    // One clock: apply the model to this cycle's inputs, step, then check and respond as memory.
    task automatic cycle();
        logic [31:0] r;
        bit acc;
        if (i_pose_valid) latest_pose = i_pose;
        if (i_start && !model_busy) begin
            model_busy = 1; exp_pose = latest_pose;
            exp_addr = 0; out_idx = 0; acc_cnt = 0;
            first_acc = -1; last_acc = -1; first_val = -1; last_val = -1; drain_start = -1;
        end
        if (done_flag) begin model_busy = 0; done_flag = 0; end
        @(posedge i_clk); #1;
        cyc++;
        vectors++;
        if (o_pose !== exp_pose) begin
            errors++; $display("FAIL pose cyc=%0d got=%h exp=%h", cyc, o_pose, exp_pose);
        end
        vectors++;
        if (o_valid === 1'b1) begin
            if (o_data0 !== rgb_of(out_idx) || o_depth0 !== depth_of(out_idx) ||
                o_frame_start !== (out_idx == 0) || o_frame_end !== (out_idx == n_pix - 1)) begin
                errors++;
                $display("FAIL pixel idx=%0d data=%h exp=%h depth=%h exp=%h fs=%b fe=%b n=%0d",
                         out_idx, o_data0, rgb_of(out_idx), o_depth0, depth_of(out_idx),
                         o_frame_start, o_frame_end, n_pix);
            end
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
            out_idx++;
        end else if (o_valid !== 1'b0 || o_data0 !== '0 || o_depth0 !== '0 ||
                     o_frame_start !== 1'b0 || o_frame_end !== 1'b0) begin
            errors++;
            $display("FAIL idle_out cyc=%0d valid=%b data=%h depth=%h fs=%b fe=%b exp all 0",
                     cyc, o_valid, o_data0, o_depth0, o_frame_start, o_frame_end);
        end
        if (o_done === 1'b1) done_flag = 1;
        if (prev_rd_en && o_rd_en === 1'b0 && model_busy) drain_start = cyc;
        prev_rd_en = (o_rd_en === 1'b1);
        case (ready_mode)
            0:       i_rd_ready = 1'b1;
            1:       i_rd_ready = (cyc % 2 == 0);
            default: i_rd_ready = ($urandom_range(0, 3) != 0);
        endcase
        acc = (o_rd_en === 1'b1) && i_rd_ready;
        if (acc) begin
            vectors++;
            if (o_rd_addr !== ADDR_BW'(exp_addr)) begin
                errors++; $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, o_rd_addr, exp_addr);
            end
            exp_addr++; acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        for (int i = RD_LAT; i > 0; i--) begin dl_vld[i] = dl_vld[i-1]; dl_addr[i] = dl_addr[i-1]; end
        dl_vld[0] = acc; dl_addr[0] = o_rd_addr;
        r = $urandom;
        i_rd_data0  = dl_vld[RD_LAT] ? rgb_of(int'(dl_addr[RD_LAT]))   : r[RGB_BW-1:0];
        i_rd_depth0 = dl_vld[RD_LAT] ? depth_of(int'(dl_addr[RD_LAT])) : r[31:32-DEP_BW];
    endtask

    task automatic frame(input int h, input int v, input int mode, input int fe_delay,
                         input int mid_pose_at, input int start_mid, input int bypass,
                         input int corr_max);
        int  corr_sent, budget;
        bit  posed;
        r_hsize = HB'(h); r_vsize = VB'(v); ready_mode = mode; n_pix = h * v;
        corr_sent = 0; posed = 0;
        if (bypass != 0) begin i_pose = rand_pose(); i_pose_valid = 1; end
        i_start = 1; cycle(); i_start = 0; i_pose_valid = 0;
        vectors++;
        if (o_busy !== 1'b1 || o_rd_en !== 1'b1 || o_rd_addr !== '0) begin
            errors++; $display("FAIL start_state busy=%b rd_en=%b addr=%0d exp 1/1/0", o_busy, o_rd_en, o_rd_addr);
        end
        budget = 0;
        while (acc_cnt < n_pix && budget < 400) begin
            i_corr_valid = (corr_sent < corr_max);
            if (i_corr_valid) corr_sent++;
            if (!posed && mid_pose_at >= 0 && acc_cnt >= mid_pose_at) begin
                i_pose = rand_pose(); i_pose_valid = 1; posed = 1;
            end else i_pose_valid = 0;
            i_start = (start_mid != 0 && acc_cnt == 1);
            cycle(); budget++;
        end
        i_corr_valid = 0; i_pose_valid = 0; i_start = 0;
        vectors++;
        if (acc_cnt != n_pix) begin
            errors++; $display("FAIL stream_len accepted=%0d exp=%0d", acc_cnt, n_pix);
        end
        budget = 0;
        while (out_idx < n_pix && budget < 20) begin cycle(); budget++; end
        vectors++;
        if (out_idx != n_pix) begin
            errors++; $display("FAIL valid_count got=%0d exp=%0d", out_idx, n_pix);
        end
        if (mode == 0) begin
            vectors++;
            if (last_acc - first_acc != n_pix - 1 || last_val - first_val != n_pix - 1) begin
                errors++; $display("FAIL contiguous acc_span=%0d val_span=%0d exp=%0d",
                                   last_acc - first_acc, last_val - first_val, n_pix - 1);
            end
        end
        if (fe_delay >= 0) begin
            repeat (fe_delay) begin
                cycle();
                vectors++;
                if (o_done !== 1'b0 || o_busy !== 1'b1) begin
                    errors++; $display("FAIL early_done done=%b busy=%b exp 0/1", o_done, o_busy);
                end
            end
            i_corr_frame_end = 1; cycle(); i_corr_frame_end = 0;
            vectors++;
            if (o_done !== 1'b1 || o_busy !== 1'b0) begin
                errors++; $display("FAIL done_after_fe done=%b busy=%b exp 1/0", o_done, o_busy);
            end
        end else begin
            budget = 0;
            while (o_done !== 1'b1 && budget < DRAIN_MAX + 20) begin
                vectors++;
                if (o_busy !== 1'b1) begin
                    errors++; $display("FAIL drain_busy busy=%b exp 1", o_busy);
                end
                cycle(); budget++;
            end
            vectors++;
            if (o_done !== 1'b1 || o_busy !== 1'b0 || cyc - drain_start != DRAIN_MAX) begin
                errors++; $display("FAIL drain_timeout done=%b busy=%b cycles=%0d exp=%0d",
                                   o_done, o_busy, cyc - drain_start, DRAIN_MAX);
            end
        end
        cycle();
        vectors++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse done=%b busy=%b exp 0/0", o_done, o_busy);
        end
`ifdef CORR_CNT_EN
        vectors++;
        if (o_corr_cnt !== ADDR_BW'(corr_sent)) begin
            errors++; $display("FAIL corr_cnt got=%0d exp=%0d", o_corr_cnt, corr_sent);
        end
`endif
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        repeat (2) @(posedge i_clk);
        #1;
        vectors++;
        if (o_rd_en !== 1'b0 || o_valid !== 1'b0 || o_frame_start !== 1'b0 || o_frame_end !== 1'b0 ||
            o_busy !== 1'b0 || o_done !== 1'b0 || o_rd_addr !== '0 || o_data0 !== '0 ||
            o_depth0 !== '0 || o_pose !== '0) begin
            errors++; $display("FAIL reset_state rd_en=%b valid=%b busy=%b done=%b addr=%0d exp all 0",
                               o_rd_en, o_valid, o_busy, o_done, o_rd_addr);
        end
        i_rst_n = 1;
        model_reset();
        cycle();
    endtask

    task automatic test_basic();
        i_pose = rand_pose(); i_pose_valid = 1; cycle(); i_pose_valid = 0;
        frame(4, 3, 0, 1, -1, 0, 0, 5);
    endtask

    task automatic test_stall();
        frame(4, 3, 1, 2, -1, 0, 0, 4);
    endtask

    task automatic test_pose_mid();
        frame(4, 3, 0, 0, 5, 0, 0, 0);
        frame(4, 3, 0, 0, -1, 0, 0, 0);
    endtask

    task automatic test_bypass();
        i_pose = rand_pose(); i_pose_valid = 1; cycle(); i_pose_valid = 0;
        frame(3, 2, 0, 0, -1, 0, 1, 2);
    endtask

    task automatic test_start_ignored();
        frame(4, 3, 0, 2, -1, 1, 0, 3);
        frame(4, 3, 0, 0, -1, 0, 0, 0);
    endtask

    task automatic test_small_frames();
        frame(1, 1, 0, 0, -1, 0, 0, 1);
        frame(1, 4, 2, 1, -1, 0, 0, 2);
        frame(5, 1, 1, 0, 2, 0, 0, 0);
    endtask

    task automatic test_drain_timeout();
        frame(4, 3, 0, -1, -1, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int budget;
        r_hsize = HB'(4); r_vsize = VB'(3); ready_mode = 0; n_pix = 12;
        i_start = 1; cycle(); i_start = 0;
        budget = 0;
        while (acc_cnt < 5 && budget < 50) begin cycle(); budget++; end
        i_rst_n = 0; #1;
        vectors++;
        if (o_rd_en !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_rd_addr !== '0 || o_data0 !== '0 || o_depth0 !== '0 || o_pose !== '0 ||
            o_frame_start !== 1'b0 || o_frame_end !== 1'b0) begin
            errors++; $display("FAIL reset_mid rd_en=%b valid=%b busy=%b addr=%0d data=%h exp all 0",
                               o_rd_en, o_valid, o_busy, o_rd_addr, o_data0);
        end
        model_reset();
        cycle(); cycle();
        i_rst_n = 1;
        cycle();
        frame(4, 3, 0, 1, -1, 0, 0, 7);
    endtask

    task automatic test_random();
        int h, v, fe, mp, sm, bp, cm;
        for (int k = 0; k < 10; k++) begin
            h  = int'($urandom_range(1, 6));
            v  = int'($urandom_range(1, 5));
            fe = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            mp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            sm = int'($urandom_range(0, 1));
            bp = int'($urandom_range(0, 1));
            cm = int'($urandom_range(0, 8));
            if (cm > h * v) cm = h * v;
            frame(h, v, 2, fe, mp, sm, bp, cm);
        end
    endtask

    initial begin
        i_clk = 0; i_rst_n = 0; i_start = 0; i_pose_valid = 0; i_pose = '0;
        r_hsize = '0; r_vsize = '0; i_rd_ready = 0; i_rd_data0 = '0; i_rd_depth0 = '0;
        i_corr_valid = 0; i_corr_frame_end = 0;
        cyc = 0; n_pix = 1; ready_mode = 0;
        model_reset();
        test_reset();
        test_basic();
        test_stall();
        test_pose_mid();
        test_bypass();
        test_start_ignored();
        test_small_frames();
        test_drain_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
